game_ctrl: RTL and testbench

Central game sequencer for the VGA shooter. It owns the game state machine (new game, play, respawn, game over), lives, level, and the two-digit BCD score. It also schedules obstacle and bomb spawns per frame. The graphics datapath consumes its outputs to freeze or reset object positions, to scale object speed, and to display life, level and score text.

---
 rtl/game_pkg.sv | 34 +++
 rtl/game_ctrl_if.sv | 29 ++
 rtl/bcd_score_counter.sv | 43 ++++
 rtl/game_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_game_ctrl.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared types and defaults for the shooter game sequencer.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PLAY    = 2'b01,
    RESPAWN = 2'b10,
    OVER    = 2'b11
  } game_state_t;

  typedef logic [3:0] bcd_t;

  localparam int DEF_LIVES          = 3;
  localparam int DEF_HITS_PER_LEVEL = 5;
  localparam int DEF_MAX_LEVEL      = 7;
  localparam int DEF_RESPAWN_FRAMES = 60;
  localparam int DEF_SPAWN_BASE     = 90;
  localparam int DEF_SPAWN_STEP     = 10;
  localparam int DEF_OBJ_V_BASE     = 5;

  // Two-digit BCD increment that sticks at 99 instead of wrapping.
  function automatic logic [7:0] bcd_sat_inc(input bcd_t tens, input bcd_t units);
    logic [7:0] res;
    if ((tens == 4'd9) && (units == 4'd9)) begin
      res = {tens, units};
    end else if (units == 4'd9) begin
      res = {tens + 4'd1, 4'd0};
    end else begin
      res = {tens, units + 4'd1};
    end
    return res;
  endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// Event inputs and status outputs exchanged between game_ctrl and the graphics datapath.
interface game_ctrl_if;
  import game_pkg::*;

  logic       refr_tick;
  logic       start_pulse;
  logic       hit;
  logic       miss;
  logic       bomb_hit;
  logic       game_stop;
  logic       game_over;
  logic [1:0] life;
  logic [2:0] level;
  bcd_t       dig1;
  bcd_t       dig0;
  logic [3:0] obj_v;
  logic       spawn_req;
  logic       spawn_bomb;

  modport master (
    output refr_tick, start_pulse, hit, miss, bomb_hit,
    input  game_stop, game_over, life, level, dig1, dig0, obj_v, spawn_req, spawn_bomb
  );

  modport slave (
    input  refr_tick, start_pulse, hit, miss, bomb_hit,
    output game_stop, game_over, life, level, dig1, dig0, obj_v, spawn_req, spawn_bomb
  );
endinterface

// File: rtl/bcd_score_counter.sv
// Two-digit BCD score register with synchronous clear and saturating increment.
module bcd_score_counter
  import game_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output bcd_t dig1,
  output bcd_t dig0
);

  bcd_t       dig1_r;
  bcd_t       dig0_r;
  logic [7:0] nxt_s;

  // Next score: clear has priority over increment.
  always_comb begin
    nxt_s = {dig1_r, dig0_r};
    if (clr) begin
      nxt_s = 8'h00;
    end else if (inc) begin
      nxt_s = bcd_sat_inc(dig1_r, dig0_r);
    end else begin
      nxt_s = {dig1_r, dig0_r};
    end
  end

  // Score digit registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig1_r <= 4'd0;
      dig0_r <= 4'd0;
    end else begin
      dig1_r <= nxt_s[7:4];
      dig0_r <= nxt_s[3:0];
    end
  end

  assign dig1 = dig1_r;
  assign dig0 = dig0_r;

endmodule

// File: rtl/game_ctrl.sv
// Game sequencer: state machine, lives, level, score and per-frame spawn scheduling.
module game_ctrl
  import game_pkg::*;
#(
  parameter int LIVES          = DEF_LIVES,
  parameter int HITS_PER_LEVEL = DEF_HITS_PER_LEVEL,
  parameter int MAX_LEVEL      = DEF_MAX_LEVEL,
  parameter int RESPAWN_FRAMES = DEF_RESPAWN_FRAMES,
  parameter int SPAWN_BASE     = DEF_SPAWN_BASE,
  parameter int SPAWN_STEP     = DEF_SPAWN_STEP,
  parameter int OBJ_V_BASE     = DEF_OBJ_V_BASE
) (
  input logic        clk,
  input logic        rst,
  game_ctrl_if.slave bus
);

  localparam logic [1:0] LIFE_INIT = 2'(LIVES);
  localparam logic [2:0] LVL_MAX   = 3'(MAX_LEVEL);
  localparam logic [7:0] HIT_WRAP  = 8'(HITS_PER_LEVEL - 1);
  localparam logic [7:0] RESP_LOAD = 8'(RESPAWN_FRAMES);
  localparam logic [6:0] SP_BASE   = 7'(SPAWN_BASE);
  localparam logic [6:0] SP_STEP   = 7'(SPAWN_STEP);
  localparam logic [3:0] V_BASE    = 4'(OBJ_V_BASE);

  game_state_t state_r, state_s;
  logic [1:0]  life_r, life_s;
  logic [2:0]  level_r, level_s;
  logic [7:0]  hit_cnt_r, hit_cnt_s;
  logic [7:0]  resp_cnt_r, resp_cnt_s;
  logic [6:0]  spawn_cnt_r, spawn_cnt_s;
  logic [1:0]  spawn_seq_r, spawn_seq_s;
  logic        spawn_req_r, spawn_req_s;
  logic        spawn_bomb_r, spawn_bomb_s;
  logic        game_stop_r, game_over_r;
  logic [3:0]  obj_v_r;
  logic        score_clr_s, score_inc_s, loss_s;
  logic [6:0]  interval_s;
  bcd_t        dig1_s, dig0_s;

  assign loss_s     = bus.miss | bus.bomb_hit;
  assign interval_s = SP_BASE - (SP_STEP * {4'd0, level_r});

  // Next-state, scoring, life and spawn decisions.
  always_comb begin
    state_s      = state_r;
    life_s       = life_r;
    level_s      = level_r;
    hit_cnt_s    = hit_cnt_r;
    resp_cnt_s   = resp_cnt_r;
    spawn_cnt_s  = spawn_cnt_r;
    spawn_seq_s  = spawn_seq_r;
    spawn_req_s  = 1'b0;
    spawn_bomb_s = 1'b0;
    score_clr_s  = 1'b0;
    score_inc_s  = 1'b0;
    case (state_r)
      IDLE: begin
        score_clr_s = 1'b1;
        life_s      = LIFE_INIT;
        hit_cnt_s   = 8'd0;
        resp_cnt_s  = 8'd0;
        spawn_cnt_s = 7'd0;
        spawn_seq_s = 2'd0;
        if (bus.start_pulse) begin
          state_s = PLAY;
          level_s = 3'd1;
        end else begin
          state_s = IDLE;
          level_s = 3'd0;
        end
      end
      PLAY: begin
        // A hit in the same cycle as a loss still counts before the loss.
        if (bus.hit) begin
          score_inc_s = 1'b1;
          if (hit_cnt_r >= HIT_WRAP) begin
            hit_cnt_s = 8'd0;
            if (level_r < LVL_MAX) begin
              level_s = level_r + 3'd1;
            end else begin
              level_s = level_r;
            end
          end else begin
            hit_cnt_s = hit_cnt_r + 8'd1;
          end
        end else begin
          score_inc_s = 1'b0;
        end
        if (loss_s) begin
          if (life_r == 2'd1) begin
            life_s  = 2'd0;
            state_s = OVER;
          end else begin
            life_s      = life_r - 2'd1;
            resp_cnt_s  = RESP_LOAD;
            spawn_cnt_s = 7'd0;
            state_s     = RESPAWN;
          end
        end else if (bus.refr_tick) begin
          if ((spawn_cnt_r + 7'd1) >= interval_s) begin
            spawn_cnt_s  = 7'd0;
            spawn_req_s  = 1'b1;
            spawn_bomb_s = (spawn_seq_r == 2'd3);
            spawn_seq_s  = spawn_seq_r + 2'd1;
          end else begin
            spawn_cnt_s = spawn_cnt_r + 7'd1;
          end
        end else begin
          spawn_cnt_s = spawn_cnt_r;
        end
      end
      RESPAWN: begin
        if (bus.start_pulse && (resp_cnt_r == 8'd0)) begin
          state_s = PLAY;
        end else begin
          state_s = RESPAWN;
        end
        if (bus.refr_tick && (resp_cnt_r != 8'd0)) begin
          resp_cnt_s = resp_cnt_r - 8'd1;
        end else begin
          resp_cnt_s = resp_cnt_r;
        end
      end
      OVER: begin
        if (bus.start_pulse) begin
          state_s     = IDLE;
          score_clr_s = 1'b1;
          life_s      = LIFE_INIT;
          level_s     = 3'd0;
          hit_cnt_s   = 8'd0;
          resp_cnt_s  = 8'd0;
          spawn_cnt_s = 7'd0;
          spawn_seq_s = 2'd0;
        end else begin
          state_s = OVER;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      life_r       <= LIFE_INIT;
      level_r      <= 3'd0;
      hit_cnt_r    <= 8'd0;
      resp_cnt_r   <= 8'd0;
      spawn_cnt_r  <= 7'd0;
      spawn_seq_r  <= 2'd0;
      spawn_req_r  <= 1'b0;
      spawn_bomb_r <= 1'b0;
      game_stop_r  <= 1'b1;
      game_over_r  <= 1'b0;
      obj_v_r      <= V_BASE;
    end else begin
      state_r      <= state_s;
      life_r       <= life_s;
      level_r      <= level_s;
      hit_cnt_r    <= hit_cnt_s;
      resp_cnt_r   <= resp_cnt_s;
      spawn_cnt_r  <= spawn_cnt_s;
      spawn_seq_r  <= spawn_seq_s;
      spawn_req_r  <= spawn_req_s;
      spawn_bomb_r <= spawn_bomb_s;
      game_stop_r  <= (state_s != PLAY);
      game_over_r  <= (state_s == OVER);
      obj_v_r      <= V_BASE + {1'b0, level_s};
    end
  end

  bcd_score_counter u_score (
    .clk  (clk),
    .rst  (rst),
    .clr  (score_clr_s),
    .inc  (score_inc_s),
    .dig1 (dig1_s),
    .dig0 (dig0_s)
  );

  assign bus.game_stop  = game_stop_r;
  assign bus.game_over  = game_over_r;
  assign bus.life       = life_r;
  assign bus.level      = level_r;
  assign bus.dig1       = dig1_s;
  assign bus.dig0       = dig0_s;
  assign bus.obj_v      = obj_v_r;
  assign bus.spawn_req  = spawn_req_r;
  assign bus.spawn_bomb = spawn_bomb_r;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: directed table, hand sequences and random stimulus against a game-rules model.
module tb_game_ctrl;
  import game_pkg::*;

  localparam int P_LIVES = 3, P_HPL = 5, P_MAXL = 7, P_RESP = 60;
  localparam int P_SB = 90, P_SS = 10, P_VB = 5;
  localparam int M_IDLE = 0, M_PLAY = 1, M_RESP = 2, M_OVER = 3;

  logic clk;
  logic rst;
  game_ctrl_if bus();

  game_ctrl #(
    .LIVES(P_LIVES), .HITS_PER_LEVEL(P_HPL), .MAX_LEVEL(P_MAXL), .RESPAWN_FRAMES(P_RESP),
    .SPAWN_BASE(P_SB), .SPAWN_STEP(P_SS), .OBJ_V_BASE(P_VB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Game-rules model: whole-game hit total, integer score, frames left, ticks since last spawn.
  int m_mode, m_life, m_level, m_score, m_hits, m_resp, m_ticks, m_nspawn;
  int m_spawn, m_bomb;

  typedef struct {
    bit s, h, m, b, t;
    int life, level, dig1, dig0, stop, over;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_vec++;
    if (act !== 32'(exp)) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_life = P_LIVES; m_level = 0; m_score = 0; m_hits = 0;
    m_resp = 0; m_ticks = 0; m_nspawn = 0; m_spawn = 0; m_bomb = 0;
  endtask

  task automatic model_step(input bit s, input bit h, input bit ms, input bit b, input bit t);
    int interval;
    interval = P_SB - P_SS * m_level;
    m_spawn = 0;
    m_bomb  = 0;
    case (m_mode)
      M_IDLE: if (s) begin m_mode = M_PLAY; m_level = 1; end
      M_PLAY: begin
        if (h) begin
          m_score = (m_score < 99) ? m_score + 1 : 99;
          m_hits++;
          m_level = (1 + m_hits / P_HPL > P_MAXL) ? P_MAXL : 1 + m_hits / P_HPL;
        end
        if (ms || b) begin
          if (m_life == 1) begin m_life = 0; m_mode = M_OVER; end
          else begin m_life--; m_resp = P_RESP; m_ticks = 0; m_mode = M_RESP; end
        end else if (t) begin
          m_ticks++;
          if (m_ticks >= interval) begin
            m_ticks = 0; m_spawn = 1; m_bomb = (m_nspawn % 4 == 3) ? 1 : 0; m_nspawn++;
          end
        end
      end
      M_RESP: begin
        if (s && m_resp == 0) m_mode = M_PLAY;
        if (t && m_resp > 0) m_resp--;
      end
      default: if (s) model_reset();
    endcase
  endtask

  task automatic check_all();
    chk("game_stop", bus.game_stop, (m_mode != M_PLAY) ? 1 : 0);
    chk("game_over", bus.game_over, (m_mode == M_OVER) ? 1 : 0);
    chk("life", bus.life, m_life);
    chk("level", bus.level, m_level);
    chk("dig1", bus.dig1, m_score / 10);
    chk("dig0", bus.dig0, m_score % 10);
    chk("obj_v", bus.obj_v, P_VB + m_level);
    chk("spawn_req", bus.spawn_req, m_spawn);
    chk("spawn_bomb", bus.spawn_bomb, m_bomb);
  endtask

  // Called at a falling edge: drive, clock once, check at the next falling edge.
  task automatic step(input bit s, input bit h, input bit ms, input bit b, input bit t);
    bus.start_pulse = s; bus.hit = h; bus.miss = ms; bus.bomb_hit = b; bus.refr_tick = t;
    model_step(s, h, ms, b, t);
    @(posedge clk);
    #1;
    bus.start_pulse = 1'b0; bus.hit = 1'b0; bus.miss = 1'b0; bus.bomb_hit = 1'b0; bus.refr_tick = 1'b0;
    @(negedge clk);
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  int n_pulse, first_at, n_bomb, bomb_at, n_wide;

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1;
    bus.start_pulse = 1'b0; bus.hit = 1'b0; bus.miss = 1'b0; bus.bomb_hit = 1'b0; bus.refr_tick = 1'b0;
    model_reset();

    //          s  h  m  b  t  life lvl d1 d0 stop over
    tbl[0] = '{0, 0, 0, 0, 0, 3, 0, 0, 0, 1, 0};
    tbl[1] = '{1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0};
    tbl[2] = '{0, 1, 0, 0, 0, 3, 1, 0, 1, 0, 0};
    tbl[3] = '{0, 1, 1, 0, 0, 2, 1, 0, 2, 1, 0};
    tbl[4] = '{0, 1, 0, 0, 0, 2, 1, 0, 2, 1, 0};
    tbl[5] = '{1, 0, 0, 0, 0, 2, 1, 0, 2, 1, 0};

    repeat (2) @(negedge clk);
    check_all();
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      step(tbl[i].s, tbl[i].h, tbl[i].m, tbl[i].b, tbl[i].t);
      chk("tbl_life", bus.life, tbl[i].life);
      chk("tbl_level", bus.level, tbl[i].level);
      chk("tbl_dig1", bus.dig1, tbl[i].dig1);
      chk("tbl_dig0", bus.dig0, tbl[i].dig0);
      chk("tbl_stop", bus.game_stop, tbl[i].stop);
      chk("tbl_over", bus.game_over, tbl[i].over);
    end

    // Respawn hold: early start ignored, start after the full freeze resumes play.
    ticks(10);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("resp_early_start", bus.game_stop, 1);
    ticks(50);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("resp_resume", bus.game_stop, 0);

    for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("score12_tens", bus.dig1, 1);
    chk("score12_units", bus.dig0, 2);
    chk("score12_level", bus.level, 3);

    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("simul_units", bus.dig0, 3);
    chk("simul_life", bus.life, 1);
    chk("simul_stop", bus.game_stop, 1);

    ticks(60);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 90; k++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("sat_tens", bus.dig1, 9);
    chk("sat_units", bus.dig0, 9);
    chk("sat_level", bus.level, 7);

    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("over_flag", bus.game_over, 1);
    chk("over_life", bus.life, 0);
    chk("over_score", {bus.dig1, bus.dig0}, 8'h99);

    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("newgame_score", {bus.dig1, bus.dig0}, 8'h00);
    chk("newgame_life", bus.life, 3);
    chk("newgame_over", bus.game_over, 0);
    chk("newgame_level", bus.level, 0);

    // Spawn cadence at level 1: one pulse per 80 ticks, fourth one a bomb.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_pulse = 0; first_at = 0; n_bomb = 0; bomb_at = 0; n_wide = 0;
    for (int k = 1; k <= 320; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      if (bus.spawn_req === 1'b1) begin
        n_pulse++;
        if (n_pulse == 1) first_at = k;
        if (bus.spawn_bomb === 1'b1) begin n_bomb++; bomb_at = n_pulse; end
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (bus.spawn_req !== 1'b0) n_wide++;
    end
    chk("spawn_first_tick", first_at, 80);
    chk("spawn_count", n_pulse, 4);
    chk("spawn_width", n_wide, 0);
    chk("bomb_count", n_bomb, 1);
    chk("bomb_index", bomb_at, 4);

    // Random play against the model, with one asynchronous reset mid-run.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b0;
      end
      step($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 149) == 0,
           $urandom_range(0, 199) == 0, $urandom_range(0, 1) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
